// File: rtl/valid_gate.sv
`default_nettype none
// ============================================================================
//  Module   : valid_gate
//  Purpose  : Debounced N-button front end with a range-checked, latched
//             character bus and a single-action-per-press hold-off FSM.
//             Optional reject counter enabled by macro VALID_GATE_REJCNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module valid_gate #(
  parameter int N_BTN     = 3,
  parameter int W         = 5,
  parameter int MAX_VAL   = 26,
  parameter int DB_CYCLES = 250000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [W-1:0]     LET_IN,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] PULSE,
  output logic [W-1:0]     LET_OUT,
  output logic             REJ,
  output logic             BUSY,
  output logic [7:0]       REJ_CNT
);

  localparam int                 c_CNT_W  = $clog2(DB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_DB_MAX = c_CNT_W'(DB_CYCLES);
  // Any MAX_VAL at or beyond 2**W admits every code, so skip the truncated compare.
  localparam logic               c_ALL_OK = (MAX_VAL >= (2 ** W));
  localparam logic [W:0]         c_MAX    = (W+1)'(MAX_VAL);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  logic [N_BTN-1:0]   bsync1_q, bsync_q;
  logic [W-1:0]       lsync1_q, lsync_q;
  logic [N_BTN-1:0]   db_q, db_prev_q;
  logic [c_CNT_W-1:0] cnt_q [N_BTN];

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   pulse_q, pulse_d;
  logic               rej_q, rej_d;
  logic [W-1:0]       let_out_q, let_out_d;

  logic [N_BTN-1:0]   w_ev;
  logic [N_BTN-1:0]   w_sel;
  logic               w_found;
  logic               w_let_ok;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bsync1_q  <= '0;
      bsync_q   <= '0;
      lsync1_q  <= '0;
      lsync_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      bsync1_q  <= BTN;
      bsync_q   <= bsync1_q;
      lsync1_q  <= LET_IN;
      lsync_q   <= lsync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < N_BTN; i++) begin
        if (bsync_q[i] != db_q[i]) begin
          if (cnt_q[i] == c_DB_MAX) begin
            db_q[i]  <= bsync_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign w_ev     = db_q & ~db_prev_q;
  assign w_let_ok = c_ALL_OK || ({1'b0, lsync_q} < c_MAX);

  // Lowest-index press wins; simultaneous presses on other channels are dropped.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (w_ev[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pulse_d   = '0;
    rej_d     = 1'b0;
    let_out_d = let_out_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d = S_HOLD;
          if (w_let_ok) begin
            pulse_d   = w_sel;
            let_out_d = lsync_q;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (db_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      pulse_q   <= '0;
      rej_q     <= 1'b0;
      let_out_q <= '0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      rej_q     <= rej_d;
      let_out_q <= let_out_d;
    end
  end

  assign PULSE   = pulse_q;
  assign REJ     = rej_q;
  assign LET_OUT = let_out_q;
  assign BUSY    = (state_q == S_HOLD);

`ifdef VALID_GATE_REJCNT_EN
  logic [7:0] rej_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rej_cnt_q <= 8'h00;
    end else if (rej_q && (rej_cnt_q != 8'hFF)) begin
      rej_cnt_q <= rej_cnt_q + 8'd1;
    end
  end

  assign REJ_CNT = rej_cnt_q;
`else
  assign REJ_CNT = 8'h00;
`endif

endmodule
`default_nettype wire
